uart_tx_fifo: RTL and testbench

//  Output path between the Core (is_out stage) and the UART RXD_OUT pin: buffers bytes written by the

---
 rtl/uart_tx_fifo.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
// Provides near-full back-pressure, a sticky overflow flag and a registered txd line.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int BUSY_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [7:0]            output_data,
    input  logic                  output_valid,
    output logic                  output_busy,
    output logic                  txd,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  tx_active
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int PW     = DEPTH_LOG2 + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0]     DEPTH_V  = {1'b1, {DEPTH_LOG2{1'b0}}};

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    logic [7:0]        mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s, count_s;
    logic [PW-1:0]     count_r;
    logic              busy_r, overflow_r, txd_r, active_r;
    logic              full_s, empty_s, push_s, pop_s, drop_s, txd_s;
    state_t            state_r, state_s;
    logic [BAUD_W-1:0] baud_r, baud_s;
    logic [2:0]        idx_r, idx_s;
    logic [7:0]        shift_r, shift_s;
    logic              baud_end_s;
    logic [PW-1:0]     free_s;
`ifdef UART_TX_PARITY_EN
    logic              parity_r, parity_s;
`endif

    // Even-parity bit of a data byte
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    assign full_s     = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                        (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    // A pop frees a slot in the same cycle, so a push while full is still accepted then
    assign pop_s      = (state_r == ST_IDLE) && !empty_s;
    assign push_s     = output_valid && (!full_s || pop_s);
    assign drop_s     = output_valid && full_s && !pop_s;
    assign baud_end_s = (baud_r == BAUD_MAX);

    // Next-state pointers, occupancy and free space
    always_comb begin
        wr_ptr_s = wr_ptr_r + PW'(push_s);
        rd_ptr_s = rd_ptr_r + PW'(pop_s);
        count_s  = wr_ptr_s - rd_ptr_s;
        free_s   = DEPTH_V - count_s;
    end

    // FIFO storage (no reset needed on the data array)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= output_data;
        end else begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= mem_r[wr_ptr_r[DEPTH_LOG2-1:0]];
        end
    end

    // FIFO pointers, count, busy and sticky overflow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            busy_r     <= (32'(free_s) <= 32'(BUSY_MARGIN));
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Transmitter next-state and next txd value
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        txd_s   = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_s = parity_r;
`endif
        if (state_r == ST_IDLE) begin
            baud_s = '0;
        end else if (baud_end_s) begin
            baud_s = '0;
        end else begin
            baud_s = baud_r + BAUD_W'(1);
        end
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    shift_s = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
`ifdef UART_TX_PARITY_EN
                    parity_s = even_parity(mem_r[rd_ptr_r[DEPTH_LOG2-1:0]]);
`endif
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_s = ST_DATA;
                    idx_s   = 3'd0;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    shift_s = {1'b0, shift_r[7:1]};
                    idx_s   = idx_r + 3'd1;
`ifdef UART_TX_PARITY_EN
                    state_s = (idx_r == 3'd7) ? ST_PARITY : ST_DATA;
`else
                    state_s = (idx_r == 3'd7) ? ST_STOP : ST_DATA;
`endif
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                state_s = baud_end_s ? ST_STOP : ST_PARITY;
            end
`endif
            ST_STOP: begin
                state_s = baud_end_s ? ST_IDLE : ST_STOP;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // txd is registered, so it is derived from where the FSM is heading
        case (state_s)
            ST_START:  txd_s = 1'b0;
            ST_DATA:   txd_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_s = parity_s;
`endif
            default:   txd_s = 1'b1;
        endcase
    end

    // Transmitter state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            baud_r   <= '0;
            idx_r    <= 3'd0;
            shift_r  <= 8'd0;
            txd_r    <= 1'b1;
            active_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            baud_r   <= baud_s;
            idx_r    <= idx_s;
            shift_r  <= shift_s;
            txd_r    <= txd_s;
            active_r <= (state_s != ST_IDLE);
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_s;
`endif
        end
    end

    assign output_busy = busy_r;
    assign txd         = txd_r;
    assign fifo_count  = count_r;
    assign overflow    = overflow_r;
    assign tx_active   = active_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table-driven fill/overflow vectors, hand sequences,
// and a line decoder that checks every received frame against a scoreboard of pushed bytes.
module tb_uart_tx_fifo;

    localparam int CPB  = 4;
    localparam int DL2  = 3;
    localparam int HALF = CPB / 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CLKS = NBITS * CPB;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [7:0]   output_data = 8'd0;
    logic         output_valid = 1'b0;
    logic         output_busy, txd, overflow, tx_active;
    logic [DL2:0] fifo_count;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    int start_q[$];

    // monitor state
    int cyc = 0;
    int rx_cnt = 0;
    bit rx_busy = 1'b0;
    logic [7:0] rx_byte;

    uart_tx_fifo #(.DEPTH_LOG2(DL2), .CLKS_PER_BIT(CPB), .BUSY_MARGIN(2)) dut (
        .clk(clk), .rstn(rstn), .output_data(output_data), .output_valid(output_valid),
        .output_busy(output_busy), .txd(txd), .fifo_count(fifo_count),
        .overflow(overflow), .tx_active(tx_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; applies inputs across one posedge and returns at the next negedge
    task automatic drive(input logic v, input logic [7:0] d, input logic acc);
        output_valid = v;
        output_data  = d;
        if (v && acc) exp_q.push_back(d);
        @(negedge clk);
        output_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !rx_busy && !tx_active) break;
            @(negedge clk);
        end
        check({name, "_drain_timeout"}, (i < 3000) ? 32'd1 : 32'd0, 32'd1);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    // Line decoder: samples mid-bit and compares each frame with the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                rx_busy = 1'b0;
            end else if (!rx_busy) begin
                if (txd == 1'b0) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CPB == HALF) begin
                    if (rx_cnt / CPB == 0) begin
                        check("start_bit", {31'd0, txd}, 32'd0);
                    end else if (rx_cnt / CPB <= 8) begin
                        rx_byte[rx_cnt / CPB - 1] = txd;
`ifdef UART_TX_PARITY_EN
                    end else if (rx_cnt / CPB == 9) begin
                        if (exp_q.size() > 0) check("parity_bit", {31'd0, txd}, {31'd0, ^exp_q[0]});
`endif
                    end else begin
                        check("stop_bit", {31'd0, txd}, 32'd1);
                        if (exp_q.size() == 0) begin
                            check("unexpected_byte", {24'd0, rx_byte}, 32'hffffffff);
                        end else begin
                            check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                        end
                        rx_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       accept;
        logic [3:0] exp_count;
        logic       exp_busy;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int act;
        int peak;
        int sent;
        for (int i = 0; i < 10; i++) begin
            vecs[i].data   = 8'(8'h80 + i);
            vecs[i].valid  = 1'b1;
            vecs[i].accept = (i < 9) ? 1'b1 : 1'b0;
            vecs[i].exp_count = (i == 0) ? 4'd1 : ((i < 8) ? 4'(i) : 4'd8);
            vecs[i].exp_busy  = (i >= 6) ? 1'b1 : 1'b0;
            vecs[i].exp_ovf   = (i == 9) ? 1'b1 : 1'b0;
        end

        @(negedge clk);
        do_reset();
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_busy", {31'd0, output_busy}, 32'd0);
        check("rst_count", {28'd0, fifo_count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_active", {31'd0, tx_active}, 32'd0);

        // Single byte: timing of count, txd fall and frame length
        drive(1'b1, 8'h55, 1'b1);
        check("t1_count_after_push", {28'd0, fifo_count}, 32'd1);
        check("t1_txd_before_pop", {31'd0, txd}, 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        check("t1_count_after_pop", {28'd0, fifo_count}, 32'd0);
        check("t1_txd_start", {31'd0, txd}, 32'd0);
        act = 0;
        for (int i = 0; i < 200; i++) begin
            if (!tx_active) break;
            act++;
            @(negedge clk);
        end
        check("t1_active_clks", act, FRAME_CLKS);
        wait_drain("t1");

        // Three back-to-back bytes: order, peak occupancy, one idle clk between frames
        start_q.delete();
        peak = 0;
        drive(1'b1, 8'h41, 1'b1);
        if (fifo_count > peak) peak = fifo_count;
        drive(1'b1, 8'h42, 1'b1);
        if (fifo_count > peak) peak = fifo_count;
        drive(1'b1, 8'h43, 1'b1);
        if (fifo_count > peak) peak = fifo_count;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            if (fifo_count > peak) peak = fifo_count;
        end
        check("t2_peak", peak, 32'd2);
        wait_drain("t2");
        check("t2_frames", start_q.size(), 32'd3);
        if (start_q.size() == 3) begin
            check("t2_gap_ab", start_q[1] - start_q[0], FRAME_CLKS + 1);
            check("t2_gap_bc", start_q[2] - start_q[1], FRAME_CLKS + 1);
        end

        // Full FIFO with a push landing on the IDLE pop cycle
        for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h10 + i), 1'b1);
        idle(FRAME_CLKS - 7);
        check("t4_full_before", {28'd0, fifo_count}, 32'd8);
        drive(1'b1, 8'h19, 1'b1);
        check("t4_count_stays", {28'd0, fifo_count}, 32'd8);
        check("t4_no_ovf", {31'd0, overflow}, 32'd0);
        wait_drain("t4");

        // Table-driven fill: busy threshold and dropped push
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].accept);
            check($sformatf("t3_count_%0d", i), {28'd0, fifo_count}, {28'd0, vecs[i].exp_count});
            check($sformatf("t3_busy_%0d", i), {31'd0, output_busy}, {31'd0, vecs[i].exp_busy});
            check($sformatf("t3_ovf_%0d", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
        end
        wait_drain("t3");
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
        check("t3_busy_clear", {31'd0, output_busy}, 32'd0);

        do_reset();
        check("t5_ovf_cleared", {31'd0, overflow}, 32'd0);

        // 20 bytes paced by output_busy, wrapping the pointers
        sent = 0;
        for (int i = 0; i < 2000 && sent < 20; i++) begin
            if (!output_busy) begin
                drive(1'b1, 8'(sent), 1'b1);
                sent++;
            end else begin
                drive(1'b0, 8'h00, 1'b0);
            end
        end
        check("t5_all_sent", sent, 32'd20);
        wait_drain("t5");

        // Reset in the middle of data bit 3
        drive(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
        idle(9);
        check("t6_txd_bit3", {31'd0, txd}, 32'd0);
        check("t6_count_pre", {28'd0, fifo_count}, 32'd8);
        check("t6_ovf_pre", {31'd0, overflow}, 32'd1);
        #2;
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("t6_txd_async", {31'd0, txd}, 32'd1);
        check("t6_count_rst", {28'd0, fifo_count}, 32'd0);
        check("t6_ovf_rst", {31'd0, overflow}, 32'd0);
        check("t6_active_rst", {31'd0, tx_active}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        drive(1'b1, 8'hA5, 1'b1);
        wait_drain("t6");

`ifdef UART_TX_PARITY_EN
        drive(1'b1, 8'h07, 1'b1);
        drive(1'b1, 8'h03, 1'b1);
        wait_drain("t7");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
